// File: rtl/ula_muldiv.sv
// ula_muldiv: iterative radix-2 mult/div unit with private HI/LO.
// Decodes Type-R funct for mult/div, mfhi/mflo and mthi/mtlo.
module ula_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MTLO = 6'b010011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t r_state, w_nstate;

  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_div;
  logic               r_sa;
  logic               r_sb;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_dz;

  logic               w_idle;
  logic               w_long;
  logic               w_mthi;
  logic               w_mtlo;
  logic               w_last;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_msum;
  logic [2*WIDTH-1:0] w_mnext;
  logic [WIDTH:0]     w_dshift;
  logic [WIDTH:0]     w_ddiff;
  logic [2*WIDTH-1:0] w_dnext;
  logic               w_neg;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;
  logic [WIDTH-1:0]   w_qf;
  logic [WIDTH-1:0]   w_rf;

  assign w_idle = (r_state == S_IDLE);
  assign w_long = start && w_idle && (func[5:2] == 4'b0110);
  assign w_mthi = start && w_idle && (func == F_MTHI);
  assign w_mtlo = start && w_idle && (func == F_MTLO);
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // funct bit 0 clear selects the signed variant
  assign w_neg_a = ~func[0] & rs_val[WIDTH-1];
  assign w_neg_b = ~func[0] & rt_val[WIDTH-1];
  assign w_abs_a = w_neg_a ? -rs_val : rs_val;
  assign w_abs_b = w_neg_b ? -rt_val : rt_val;

  // acc = {partial product, remaining multiplier bits}
  assign w_msum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                 + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_mnext = {w_msum, r_acc[WIDTH-1:1]};

  // acc = {partial remainder, dividend/quotient bits}
  assign w_dshift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ddiff  = w_dshift - {1'b0, r_b};
  assign w_dnext  = w_ddiff[WIDTH]
                  ? {w_dshift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                  : {w_ddiff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_neg  = r_sa ^ r_sb;
  assign w_prod = w_neg ? -r_acc : r_acc;
  assign w_q    = r_acc[WIDTH-1:0];
  assign w_r    = r_acc[2*WIDTH-1:WIDTH];
  assign w_qf   = w_neg ? -w_q : w_q;
  assign w_rf   = r_sa ? -w_r : w_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      S_IDLE:  if (w_long) w_nstate = S_RUN;
      S_RUN:   if (w_last) w_nstate = S_FIX;
      S_FIX:   w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_div  <= 1'b0;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      if (w_long) begin
        r_div <= func[1];
        r_sa  <= w_neg_a;
        r_sb  <= w_neg_b;
        r_b   <= w_abs_b;
        r_cnt <= '0;
        // divide keeps the raw dividend for the zero-divisor result
        if (func[1]) begin
          r_acc <= {{WIDTH{1'b0}}, w_abs_a};
          r_a   <= rs_val;
        end else begin
          r_acc <= {{WIDTH{1'b0}}, w_abs_b};
          r_a   <= w_abs_a;
        end
      end
      if (w_mthi) r_hi <= rs_val;
      if (w_mtlo) r_lo <= rs_val;
      if (r_state == S_RUN) begin
        r_acc <= r_div ? w_dnext : w_mnext;
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
      if (r_state == S_FIX) begin
        r_done <= 1'b1;
        if (!r_div) begin
          {r_hi, r_lo} <= w_prod;
        end else if (r_b == '0) begin
          r_lo <= '1;
          r_hi <= r_a;
          r_dz <= 1'b1;
        end else begin
          r_lo <= w_qf;
          r_hi <= w_rf;
        end
      end
    end
  end

  assign busy     = ~w_idle;
  assign done     = r_done;
  assign div_zero = r_dz;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign rd_data  = (func == F_MFHI) ? r_hi : r_lo;

endmodule
